// File: rtl/fault_sup_pkg.sv
// ============================================================================
// Module  : fault_sup_pkg
// Brief   : Shared types and constants for the N-channel fault supervisor.
//           Holds the bypass FSM state type, the default µs counter width
//           and the first-fault index width.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fault_sup_pkg;

    // Default width of every µs counter in the supervisor
    localparam int c_cnt_w_def  = 14;

    // Width of the first-fault channel index (covers up to 32 channels)
    localparam int c_first_ch_w = 5;

    // Automatic bypass sequence states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_CLOSE = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } byp_state_t;

endpackage : fault_sup_pkg

`default_nettype wire

// File: rtl/fault_debounce.sv
// ============================================================================
// Module  : fault_debounce
// Brief   : Single fault channel: 2-FF synchroniser for the asynchronous
//           fault pin, followed by a µs debounce counter that saturates at
//           DEB_US. filt is high while the counter sits at DEB_US.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fault_debounce
    import fault_sup_pkg::*;
#(
    parameter int CNT_W  = c_cnt_w_def,
    parameter int DEB_US = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic time_1us,
    input  logic fault_raw,
    input  logic masked,
    output logic filt
);

    localparam logic [CNT_W-1:0] c_deb = CNT_W'(DEB_US);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous fault pin into the clk domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= fault_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count µs ticks while the fault is present; any absence (or a mask)
    // clears immediately, even if a tick arrives in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!r_sync2 || masked) begin
            r_cnt <= '0;
        end else if (time_1us && (r_cnt != c_deb)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign filt = (r_cnt == c_deb);

endmodule : fault_debounce

`default_nettype wire

// File: rtl/fault_supervisor.sv
// ============================================================================
// Module  : fault_supervisor
// Brief   : N-channel fault supervisor. Debounces raw fault pins, latches
//           qualified faults into err_info, optionally records the first
//           fault, and escalates selected faults into an irreversible
//           bypass-close sequence with close-confirmation timeout.
//           Optional feature macro: FAULT_SUP_FIRST_FAULT_EN
//           (defined = first-fault capture present; undefined = first_ch
//           and first_vld tied to 0).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fault_supervisor
    import fault_sup_pkg::*;
#(
    parameter int              N_CH         = 12,
    parameter int              CNT_W        = c_cnt_w_def,
    parameter int              DEB_US       = 10,
    parameter logic [N_CH-1:0] BYP_MASK     = '1,
    parameter int              BYP_DELAY_US = 1000,
    parameter int              BYP_TMO_US   = 2000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    time_1us,
    input  logic                    reset_unit,
    input  logic [N_CH-1:0]         fault_in,
    input  logic [N_CH-1:0]         ch_mask,
    input  logic                    byp_req_ext,
    input  logic                    byp_ok,
    output logic [N_CH-1:0]         err_info,
    output logic                    err_unit,
    output logic [c_first_ch_w-1:0] first_ch,
    output logic                    first_vld,
    output logic                    byp_con,
    output logic                    byp_fail
);

    localparam logic [CNT_W-1:0] c_delay   = CNT_W'(BYP_DELAY_US);
    localparam logic [CNT_W-1:0] c_tmo     = CNT_W'(BYP_TMO_US);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [N_CH-1:0]  w_filt;
    logic [N_CH-1:0]  w_err_nxt;
    logic [N_CH-1:0]  r_err_info;
    logic             w_byp_any;
    byp_state_t       r_state;
    byp_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_byp_con;
    logic             r_byp_fail;

    // ------------------------------------------------------------------
    // Per-channel synchroniser + debounce
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            fault_debounce #(
                .CNT_W  (CNT_W),
                .DEB_US (DEB_US)
            ) u_deb (
                .clk       (clk),
                .rst_n     (rst_n),
                .time_1us  (time_1us),
                .fault_raw (fault_in[i]),
                .masked    (ch_mask[i]),
                .filt      (w_filt[i])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Fault latch: a qualified fault always sets; reset_unit only clears
    // channels whose filtered fault has gone away
    // ------------------------------------------------------------------
    assign w_err_nxt = w_filt | (r_err_info & {N_CH{~reset_unit}});

    // Latch qualified faults
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_info <= '0;
        end else begin
            r_err_info <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // First-fault capture
    // ------------------------------------------------------------------
`ifdef FAULT_SUP_FIRST_FAULT_EN
    logic [N_CH-1:0]         w_new;
    logic [c_first_ch_w-1:0] w_low_idx;
    logic [c_first_ch_w-1:0] r_first_ch;
    logic                    r_first_vld;

    assign w_new = w_filt & ~r_err_info;

    // Lowest-numbered channel that is setting in this cycle
    always_comb begin
        w_low_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_new[i]) begin
                w_low_idx = c_first_ch_w'(i);
            end
        end
    end

    // Hold the first fault until the latch is fully cleared by reset_unit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_first_ch  <= '0;
            r_first_vld <= 1'b0;
        end else if (!r_first_vld && (|w_new)) begin
            r_first_ch  <= w_low_idx;
            r_first_vld <= 1'b1;
        end else if (reset_unit && (w_err_nxt == '0)) begin
            r_first_vld <= 1'b0;
        end
    end

    assign first_ch  = r_first_ch;
    assign first_vld = r_first_vld;
`else
    assign first_ch  = '0;
    assign first_vld = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Bypass sequence
    // ------------------------------------------------------------------
    assign w_byp_any = |(w_filt & BYP_MASK);
    assign w_cnt_inc = (time_1us && (r_cnt != c_cnt_max)) ? (r_cnt + 1'b1) : r_cnt;

    // State and µs counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_d;
        end
    end

    // Next-state logic; CLOSE/DONE/FAIL are left only through rst_n
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_d     = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_cnt_d = '0;
                if (byp_req_ext) begin
                    w_state_nxt = ST_CLOSE;
                end else if (w_byp_any) begin
                    w_state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (byp_req_ext) begin
                    w_state_nxt = ST_CLOSE;
                    w_cnt_d     = '0;
                end else if (reset_unit || !w_byp_any) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_d     = '0;
                end else if (w_cnt_inc == c_delay) begin
                    w_state_nxt = ST_CLOSE;
                    w_cnt_d     = '0;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            ST_CLOSE: begin
                if (byp_ok) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_d     = '0;
                end else if (w_cnt_inc == c_tmo) begin
                    w_state_nxt = ST_FAIL;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            ST_DONE: begin
                if (!byp_ok) begin
                    w_state_nxt = ST_FAIL;
                end
            end
            ST_FAIL: begin
                w_state_nxt = ST_FAIL;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_d     = '0;
            end
        endcase
    end

    // Registered bypass outputs, decoded from the state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byp_con  <= 1'b0;
            r_byp_fail <= 1'b0;
        end else begin
            r_byp_con  <= (r_state == ST_CLOSE) || (r_state == ST_DONE) ||
                          (r_state == ST_FAIL);
            r_byp_fail <= (r_state == ST_FAIL);
        end
    end

    assign err_info = r_err_info;
    assign err_unit = (|r_err_info) | r_byp_fail;
    assign byp_con  = r_byp_con;
    assign byp_fail = r_byp_fail;

endmodule : fault_supervisor

`default_nettype wire
